// File: rtl/awg_sweep_ctrl_if.sv
// Host/generator-side signal bundle for awg_sweep_ctrl: sweep configuration and
// control pulses in, generator drive and status out.
interface awg_sweep_ctrl_if #(
  parameter int unsigned FREQ_W  = 12,
  parameter int unsigned DWELL_W = 16
);
  logic [FREQ_W-1:0]  cfg_start_freq;
  logic [FREQ_W-1:0]  cfg_stop_freq;
  logic [FREQ_W-1:0]  cfg_step;
  logic [DWELL_W-1:0] cfg_dwell;
  logic [1:0]         cfg_mode;
  logic [2:0]         cfg_amp;
  logic [7:0]         cfg_phase;
  logic               start;
  logic               abort;
  logic [FREQ_W-1:0]  freq_out;
  logic [2:0]         amp_out;
  logic [7:0]         phase_out;
  logic               gen_en;
  logic               busy;
  logic               done;
  logic               step_strobe;
  logic               cfg_err;

  modport master (
    output cfg_start_freq, cfg_stop_freq, cfg_step, cfg_dwell, cfg_mode,
           cfg_amp, cfg_phase, start, abort,
    input  freq_out, amp_out, phase_out, gen_en, busy, done, step_strobe, cfg_err
  );

  modport slave (
    input  cfg_start_freq, cfg_stop_freq, cfg_step, cfg_dwell, cfg_mode,
           cfg_amp, cfg_phase, start, abort,
    output freq_out, amp_out, phase_out, gen_en, busy, done, step_strobe, cfg_err
  );
endinterface

// File: rtl/awg_sweep_ctrl.sv
// Frequency sweep sequencer for a square-wave generator channel: steps the
// phase-increment word between latched limits, holding each value dwell+1 clocks.
module awg_sweep_ctrl #(
  parameter int unsigned FREQ_W  = 12,
  parameter int unsigned DWELL_W = 16
) (
  input logic             clk,
  input logic             rst_n,
  awg_sweep_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [FREQ_W-1:0]  freq_q, freq_d;
  logic [FREQ_W-1:0]  start_q, start_d;
  logic [FREQ_W-1:0]  stop_q, stop_d;
  logic [FREQ_W-1:0]  step_q, step_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [1:0]         mode_q, mode_d;
  logic [2:0]         amp_q, amp_d;
  logic [7:0]         phase_q, phase_d;
  logic               dir_dn_q, dir_dn_d;
  logic               gen_en_q, gen_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               strobe_q, strobe_d;
  logic               err_q, err_d;

  logic [FREQ_W:0]    up_sum;
  logic [FREQ_W:0]    dn_floor;
  logic [FREQ_W-1:0]  up_next;
  logic [FREQ_W-1:0]  dn_next;
  logic               cfg_bad;

  // One extra bit keeps freq+step and start+step from wrapping near full scale.
  always_comb begin
    up_sum   = {1'b0, freq_q} + {1'b0, step_q};
    dn_floor = {1'b0, start_q} + {1'b0, step_q};
    up_next  = (up_sum >= {1'b0, stop_q}) ? stop_q : up_sum[FREQ_W-1:0];
    dn_next  = ({1'b0, freq_q} <= dn_floor) ? start_q : (freq_q - step_q);
    cfg_bad  = (bus.cfg_step == '0) || (bus.cfg_start_freq > bus.cfg_stop_freq);
  end

  always_comb begin
    state_d  = state_q;
    freq_d   = freq_q;
    start_d  = start_q;
    stop_d   = stop_q;
    step_d   = step_q;
    dwell_d  = dwell_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    amp_d    = amp_q;
    phase_d  = phase_q;
    dir_dn_d = dir_dn_q;
    gen_en_d = gen_en_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    strobe_d = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          if (cfg_bad) begin
            err_d = 1'b1;
          end else begin
            start_d  = bus.cfg_start_freq;
            stop_d   = bus.cfg_stop_freq;
            step_d   = bus.cfg_step;
            dwell_d  = bus.cfg_dwell;
            mode_d   = bus.cfg_mode;
            amp_d    = (bus.cfg_amp == '0) ? 3'd1 : bus.cfg_amp;
            phase_d  = bus.cfg_phase;
            freq_d   = bus.cfg_start_freq;
            cnt_d    = '0;
            dir_dn_d = 1'b0;
            state_d  = RUN;
            busy_d   = 1'b1;
            gen_en_d = 1'b1;
            strobe_d = 1'b1;
          end
        end
      end

      RUN: begin
        if (bus.abort) begin
          state_d  = IDLE;
          gen_en_d = 1'b0;
          busy_d   = 1'b0;
        end else if (cnt_q == dwell_q) begin
          cnt_d = '0;
          if (!dir_dn_q) begin
            if (freq_q != stop_q) begin
              freq_d   = up_next;
              strobe_d = 1'b1;
            end else begin
              unique case (mode_q)
                2'b01: begin
                  freq_d   = start_q;
                  strobe_d = 1'b1;
                end
                2'b10: begin
                  dir_dn_d = 1'b1;
                  freq_d   = dn_next;
                  strobe_d = 1'b1;
                end
                default: begin
                  state_d  = DONE;
                  done_d   = 1'b1;
                  busy_d   = 1'b0;
                  gen_en_d = 1'b0;
                end
              endcase
            end
          end else begin
            strobe_d = 1'b1;
            if (freq_q != start_q) begin
              freq_d = dn_next;
            end else begin
              dir_dn_d = 1'b0;
              freq_d   = up_next;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      freq_q   <= '0;
      start_q  <= '0;
      stop_q   <= '0;
      step_q   <= '0;
      dwell_q  <= '0;
      cnt_q    <= '0;
      mode_q   <= '0;
      amp_q    <= '0;
      phase_q  <= '0;
      dir_dn_q <= 1'b0;
      gen_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      freq_q   <= freq_d;
      start_q  <= start_d;
      stop_q   <= stop_d;
      step_q   <= step_d;
      dwell_q  <= dwell_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      amp_q    <= amp_d;
      phase_q  <= phase_d;
      dir_dn_q <= dir_dn_d;
      gen_en_q <= gen_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
    end
  end

  assign bus.freq_out    = freq_q;
  assign bus.amp_out     = amp_q;
  assign bus.phase_out   = phase_q;
  assign bus.gen_en      = gen_en_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.step_strobe = strobe_q;
  assign bus.cfg_err     = err_q;

endmodule

// File: doc/awg_sweep_ctrl.md
Name: awg_sweep_ctrl

Overview:
Sequencer that drives the freq/amp/phase/en inputs of a square-wave generator channel to perform frequency sweeps.
- A host loads sweep limits, step size, dwell time and mode, then pulses start.
- The block steps the generator's phase-increment word through the programmed range and holds each value for a fixed number of clocks.
- It sits between the host control registers and the generator.

Parameters:
FREQ_W, 12, width of frequency word (generator phase increment)
DWELL_W, 16, width of dwell counter

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
cfg_start_freq  input  FREQ_W  sweep start frequency word
cfg_stop_freq  input  FREQ_W  sweep stop frequency word
cfg_step  input  FREQ_W  frequency increment per step
cfg_dwell  input  DWELL_W  hold time per frequency, in clocks minus 1
cfg_mode  input  2  00 single up, 01 continuous sawtooth, 10 continuous triangle, 11 reserved (treated as 00)
cfg_amp  input  3  amplitude divisor for generator
cfg_phase  input  8  channel B phase offset for generator
start  input  1  one-cycle pulse, begin sweep
abort  input  1  one-cycle pulse, stop sweep
freq_out  output  FREQ_W  to generator freq
amp_out  output  3  to generator amp
phase_out  output  8  to generator phase
gen_en  output  1  to generator en
busy  output  1  sweep in progress
done  output  1  one-cycle pulse, single sweep finished
step_strobe  output  1  one-cycle pulse on every new freq_out value
cfg_err  output  1  one-cycle pulse, start rejected

Behaviour:
Clock and reset:
- One clock (clk). Reset rst_n is synchronous, active-low.
- Reset (any state, including mid-sweep): state IDLE; freq_out=0, amp_out=0, phase_out=0, gen_en=0, busy=0, done=0, step_strobe=0, cfg_err=0; dwell counter=0; direction=up.
- All outputs are registered.

States: IDLE, RUN, DONE.

IDLE:
- start=1 and abort=0 with a bad config (cfg_step==0, or cfg_start_freq>cfg_stop_freq):
  - cfg_err=1 for one cycle.
  - Stay in IDLE; no other output changes.
- start=1 and abort=0 with a valid config:
  - Latch all cfg_* inputs into shadow registers.
  - Next cycle: state RUN, busy=1, gen_en=1, freq_out=start, step_strobe=1, dwell counter=0, direction=up.
  - amp_out = latched cfg_amp, except 0 is forced to 1 (generator divides by amp).
  - phase_out = latched cfg_phase.
- cfg_* changes after the latch have no effect until the next start.
- start and abort in the same cycle: abort wins; stay in IDLE.

RUN:
- Each freq_out value is held exactly dwell+1 cycles.
- The counter increments each cycle. When counter==dwell, the next cycle loads the next frequency, step_strobe=1, counter=0.
- Next-frequency rules: all sums computed FREQ_W+1 bits wide, no overflow wrap.
  - Up, freq<stop: next = min(freq+step, stop).
  - Up, freq==stop:
    - mode 00/11: go to DONE.
    - mode 01: next = start.
    - mode 10: direction=down, next = max(freq-step, start); if start==stop, next=start.
  - Down, freq>start: next = max(freq-step, start).
  - Down, freq==start: direction=up, next = min(start+step, stop).
- start==stop:
  - mode 00: one dwell, then DONE.
  - Modes 01/10: hold start freq indefinitely, with step_strobe every dwell+1 cycles.
- start while in RUN: ignored.
- abort in RUN: next cycle state IDLE, gen_en=0, busy=0, no done pulse; freq_out/amp_out/phase_out retain their last values.

DONE:
- Lasts one cycle: done=1, busy=0, gen_en=0, freq_out retains stop.
- Then IDLE.
- start during DONE is ignored.

Latency:
- start to gen_en/freq_out valid: 1 cycle.
- Single-mode total time from first step_strobe to done = N*(dwell+1) cycles, where N = number of distinct frequencies visited.

Test Plan:
1. Reset mid-RUN (rst_n=0 for 1 cycle) -> next cycle all outputs 0, state IDLE, subsequent start behaves normally.
2. Single sweep: start=100, stop=130, step=10, dwell=3, mode=00 -> freq_out 100,110,120,130, each held 4 cycles; step_strobe 4 times; done 1 cycle after the last 130 cycle; gen_en deasserts with done.
3. Clamp and sawtooth: start=0, stop=25, step=10, dwell=0, mode=01 -> freq_out 0,10,20,25,0,10,... one cycle each; never exceeds 25; busy stays 1 until abort; abort -> gen_en=0 next cycle, no done.
4. Triangle: start=4095-10=4085, stop=4095, step=8, dwell=1, mode=10 -> 4085,4093,4095,4087,4085,4093,... each 2 cycles; no 12-bit overflow.
5. Config errors: step=0 -> cfg_err pulse, busy stays 0; start=50, stop=40 -> cfg_err; cfg_amp=0 valid sweep -> amp_out=1.
6. Control collisions: start+abort same cycle in IDLE -> stays IDLE; start pulse during RUN -> sequence unchanged; cfg_stop changed mid-sweep -> sweep ends at the latched stop.
